lcd_hd44780_receiver: RTL and testbench

//  Responder end of the vending machine's HD44780 text-LCD write bus. It samples lcd_e/rs/rw/data,

---
 rtl/vm_lcd_pkg.sv | 35 +++
 rtl/lcd_ddram_addr_step.sv | 22 ++
 rtl/lcd_hd44780_receiver.sv | 180 ++++++++++++++++++
 tb/tb_lcd_hd44780_receiver.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_lcd_pkg.sv
// Shared definitions for the HD44780 write-bus responder: instruction bit
// positions, DDRAM line geometry and the transfer FSM states.
package vm_lcd_pkg;

    localparam int unsigned INSTR_SET_DDRAM  = 7;
    localparam int unsigned INSTR_SET_CGRAM  = 6;
    localparam int unsigned INSTR_FUNC_SET   = 5;
    localparam int unsigned INSTR_SHIFT      = 4;
    localparam int unsigned INSTR_DISP_CTRL  = 3;
    localparam int unsigned INSTR_ENTRY_MODE = 2;
    localparam int unsigned INSTR_HOME       = 1;
    localparam int unsigned INSTR_CLEAR      = 0;

    localparam int unsigned SHIFT_SC_BIT = 3;
    localparam int unsigned SHIFT_RL_BIT = 2;
    localparam int unsigned DISP_D_BIT   = 2;
    localparam int unsigned DISP_C_BIT   = 1;
    localparam int unsigned DISP_B_BIT   = 0;
    localparam int unsigned ENTRY_ID_BIT = 1;

    localparam logic [6:0] LINE1_BASE     = 7'h00;
    localparam logic [6:0] LINE2_BASE     = 7'h40;
    localparam logic [6:0] LINE1_WRAP_END = 7'h27;
    localparam logic [6:0] LINE2_WRAP_END = 7'h67;
    localparam int unsigned LINE_LEN      = 16;
    localparam logic [7:0] CHAR_SPACE     = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        E_HIGH,
        COMMIT,
        CLEAR
    } lcd_state_e;

endpackage

// File: rtl/lcd_ddram_addr_step.sv
// Next address-counter value for one increment/decrement step, wrapping
// between the two 40-character DDRAM lines.
module lcd_ddram_addr_step
    import vm_lcd_pkg::*;
(
    input  logic [6:0] ac,
    input  logic       inc,
    output logic [6:0] ac_next
);

    always_comb begin
        ac_next = inc ? ac + 7'd1 : ac - 7'd1;
        if (inc) begin
            if (ac == LINE1_WRAP_END)      ac_next = LINE2_BASE;
            else if (ac == LINE2_WRAP_END) ac_next = LINE1_BASE;
        end else begin
            if (ac == LINE1_BASE)          ac_next = LINE2_WRAP_END;
            else if (ac == LINE2_BASE)     ac_next = LINE1_WRAP_END;
        end
    end

endmodule

// File: rtl/lcd_hd44780_receiver.sv
// HD44780 write-bus responder: commits transfers on the lcd_e falling edge and
// maintains a 2x16 DDRAM image plus the display-control state.
module lcd_hd44780_receiver
    import vm_lcd_pkg::*;
#(
    parameter int unsigned MIN_E_HIGH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lcd_e,
    input  logic         lcd_rs,
    input  logic         lcd_rw,
    input  logic [7:0]   lcd_data,
    output logic [127:0] line1_text,
    output logic [127:0] line2_text,
    output logic [6:0]   ddram_address,
    output logic         display_on,
    output logic         cursor_on,
    output logic         cursor_blink,
    output logic         busy,
    output logic         write_strobe,
    output logic         proto_error
);

    localparam int unsigned CNT_W = (MIN_E_HIGH < 2) ? 1 : $clog2(MIN_E_HIGH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_E_HIGH);

    lcd_state_e       state_q, state_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d, rw_q, rw_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       ac_q, ac_d, ac_step;
    logic             id_q, id_d;
    logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic [3:0]       clr_idx_q, clr_idx_d;
    logic             busy_err_q, busy_err_d;
    logic [7:0]       line1_q [LINE_LEN];
    logic [7:0]       line1_d [LINE_LEN];
    logic [7:0]       line2_q [LINE_LEN];
    logic [7:0]       line2_d [LINE_LEN];
    logic             fall, accept;

    lcd_ddram_addr_step u_step (
        .ac      (ac_q),
        .inc     (rs_q ? id_q : data_q[SHIFT_RL_BIT]),
        .ac_next (ac_step)
    );

    assign fall   = e_q && !lcd_e;
    assign accept = (cnt_q >= CNT_MAX) && !rw_q;

    always_comb begin
        state_d      = state_q;
        e_d          = lcd_e;
        rs_d         = rs_q;
        rw_d         = rw_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        ac_d         = ac_q;
        id_d         = id_q;
        disp_d       = disp_q;
        cur_d        = cur_q;
        blink_d      = blink_q;
        clr_idx_d    = clr_idx_q;
        busy_err_d   = 1'b0;
        line1_d      = line1_q;
        line2_d      = line2_q;
        write_strobe = 1'b0;
        proto_error  = busy_err_q;

        if (lcd_e) begin
            rs_d   = lcd_rs;
            rw_d   = lcd_rw;
            data_d = lcd_data;
            if (!e_q)                cnt_d = CNT_W'(1);
            else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE:   if (lcd_e) state_d = E_HIGH;
            E_HIGH: if (!lcd_e) state_d = COMMIT;
            COMMIT: begin
                state_d = lcd_e ? E_HIGH : IDLE;
                if (!accept) begin
                    proto_error = 1'b1;
                end else begin
                    write_strobe = 1'b1;
                    if (rs_q) begin
                        if (ac_q[6:4] == LINE1_BASE[6:4])      line1_d[ac_q[3:0]] = data_q;
                        else if (ac_q[6:4] == LINE2_BASE[6:4]) line2_d[ac_q[3:0]] = data_q;
                        ac_d = ac_step;
                    end else if (data_q[INSTR_SET_DDRAM]) begin
                        ac_d = data_q[6:0];
                    end else if (data_q[INSTR_SET_CGRAM] || data_q[INSTR_FUNC_SET]) begin
                        // CGRAM address and function set are acknowledged only
                    end else if (data_q[INSTR_SHIFT]) begin
                        if (!data_q[SHIFT_SC_BIT]) ac_d = ac_step;
                    end else if (data_q[INSTR_DISP_CTRL]) begin
                        disp_d  = data_q[DISP_D_BIT];
                        cur_d   = data_q[DISP_C_BIT];
                        blink_d = data_q[DISP_B_BIT];
                    end else if (data_q[INSTR_ENTRY_MODE]) begin
                        id_d = data_q[ENTRY_ID_BIT];
                    end else if (data_q[INSTR_HOME]) begin
                        ac_d = '0;
                    end else if (data_q[INSTR_CLEAR]) begin
                        ac_d      = '0;
                        id_d      = 1'b1;
                        clr_idx_d = '0;
                        state_d   = CLEAR;
                    end
                end
            end
            CLEAR: begin
                line1_d[clr_idx_q] = CHAR_SPACE;
                line2_d[clr_idx_q] = CHAR_SPACE;
                clr_idx_d  = clr_idx_q + 4'd1;
                // a strobe ending inside the clear is dropped and flagged next cycle
                busy_err_d = fall;
                if (clr_idx_q == 4'(LINE_LEN - 1)) state_d = lcd_e ? E_HIGH : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            data_q     <= '0;
            cnt_q      <= '0;
            ac_q       <= '0;
            id_q       <= 1'b1;
            disp_q     <= 1'b0;
            cur_q      <= 1'b0;
            blink_q    <= 1'b0;
            clr_idx_q  <= '0;
            busy_err_q <= 1'b0;
            for (int unsigned i = 0; i < LINE_LEN; i++) begin
                line1_q[i] <= CHAR_SPACE;
                line2_q[i] <= CHAR_SPACE;
            end
        end else begin
            state_q    <= state_d;
            e_q        <= e_d;
            rs_q       <= rs_d;
            rw_q       <= rw_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            ac_q       <= ac_d;
            id_q       <= id_d;
            disp_q     <= disp_d;
            cur_q      <= cur_d;
            blink_q    <= blink_d;
            clr_idx_q  <= clr_idx_d;
            busy_err_q <= busy_err_d;
            line1_q    <= line1_d;
            line2_q    <= line2_d;
        end
    end

    always_comb begin
        line1_text = '0;
        line2_text = '0;
        for (int unsigned i = 0; i < LINE_LEN; i++) begin
            line1_text[(LINE_LEN-1-i)*8 +: 8] = line1_q[i];
            line2_text[(LINE_LEN-1-i)*8 +: 8] = line2_q[i];
        end
    end

    assign ddram_address = ac_q;
    assign display_on    = disp_q;
    assign cursor_on     = cur_q;
    assign cursor_blink  = blink_q;
    assign busy          = (state_q == CLEAR);

endmodule

// File: tb/tb_lcd_hd44780_receiver.sv
// Scoreboarded bench for lcd_hd44780_receiver: expected pulse kinds are queued
// per strobe, and a reference model of DDRAM/AC/display state is compared per test.
module tb_lcd_hd44780_receiver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lcd_e = 1'b0, lcd_e4 = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_data = 8'h00;

    logic [127:0] line1_text, line2_text, l1_4, l2_4;
    logic [6:0]   ddram_address, ac4;
    logic display_on, cursor_on, cursor_blink, busy, write_strobe, proto_error;
    logic disp4, cur4, blink4, busy4, ws4, err4;

    lcd_hd44780_receiver dut (
        .clk(clk), .rst(rst_n), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .line1_text(line1_text), .line2_text(line2_text),
        .ddram_address(ddram_address), .display_on(display_on), .cursor_on(cursor_on),
        .cursor_blink(cursor_blink), .busy(busy), .write_strobe(write_strobe),
        .proto_error(proto_error)
    );

    lcd_hd44780_receiver #(.MIN_E_HIGH(4)) dut4 (
        .clk(clk), .rst(rst_n), .lcd_e(lcd_e4), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .line1_text(l1_4), .line2_text(l2_4),
        .ddram_address(ac4), .display_on(disp4), .cursor_on(cur4),
        .cursor_blink(blink4), .busy(busy4), .write_strobe(ws4),
        .proto_error(err4)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] ALL_SPACES = {16{8'h20}};

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int ws_count = 0, busy_cycles = 0, ws4_count = 0, err4_count = 0;

    logic [7:0] m_l1 [16];
    logic [7:0] m_l2 [16];
    logic [6:0] m_ac;
    logic m_id, m_disp, m_cur, m_blink;

    function automatic logic [6:0] ref_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h67;
        if (a == 7'h40) return 7'h27;
        return a - 7'd1;
    endfunction

    function automatic logic [127:0] exp_line(input bit second);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = second ? m_l2[i] : m_l1[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_l1[i] = 8'h20;
            m_l2[i] = 8'h20;
        end
        m_ac = 7'h00; m_id = 1'b1; m_disp = 1'b0; m_cur = 1'b0; m_blink = 1'b0;
    endtask

    task automatic model_apply(input bit rs, input logic [7:0] d);
        if (rs) begin
            if (m_ac <= 7'h0F) m_l1[m_ac[3:0]] = d;
            else if (m_ac >= 7'h40 && m_ac <= 7'h4F) m_l2[m_ac[3:0]] = d;
            m_ac = ref_step(m_ac, m_id);
        end else begin
            casez (d)
                8'b1???????: m_ac = d[6:0];
                8'b01??????, 8'b001?????: ;
                8'b0001????: if (!d[3]) m_ac = ref_step(m_ac, d[2]);
                8'b00001???: {m_disp, m_cur, m_blink} = d[2:0];
                8'b000001??: m_id = d[1];
                8'b0000001?: m_ac = 7'h00;
                8'b00000001: begin
                    for (int i = 0; i < 16; i++) begin
                        m_l1[i] = 8'h20;
                        m_l2[i] = 8'h20;
                    end
                    m_ac = 7'h00; m_id = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    // One strobe on the main DUT: hi cycles of lcd_e, then gap idle negedges.
    task automatic send(input bit rs, input bit rw, input logic [7:0] d,
                        input int hi, input int gap, input bit exp_err);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        exp_q.push_back(exp_err ? 1 : 0);
        if (!exp_err) model_apply(rs, d);
        repeat (hi) @(negedge clk);
        lcd_e = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (line1_text !== ALL_SPACES) begin failures++; $display("FAIL reset_line1: got %h want %h", line1_text, ALL_SPACES); end
        checks++; if (line2_text !== ALL_SPACES) begin failures++; $display("FAIL reset_line2: got %h want %h", line2_text, ALL_SPACES); end
        checks++; if (ddram_address !== 7'h00) begin failures++; $display("FAIL reset_ac: got %h want 00", ddram_address); end
        checks++; if (display_on !== 1'b0 || cursor_on !== 1'b0 || cursor_blink !== 1'b0) begin failures++; $display("FAIL reset_disp: got %b%b%b want 000", display_on, cursor_on, cursor_blink); end
        checks++; if (write_strobe !== 1'b0 || proto_error !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_pulses: got ws=%b err=%b busy=%b want 0", write_strobe, proto_error, busy); end
    endtask

    task automatic test_display_hi();
        int ws0;
        send(1'b0, 1'b0, 8'h0C, 1, 2, 1'b0);
        ws0 = ws_count;
        send(1'b0, 1'b0, 8'h80, 1, 2, 1'b0);
        send(1'b1, 1'b0, 8'h48, 1, 2, 1'b0);
        send(1'b1, 1'b0, 8'h49, 1, 2, 1'b0);
        settle();
        checks++; if (display_on !== 1'b1 || cursor_on !== 1'b0) begin failures++; $display("FAIL hi_disp: got D=%b C=%b want D=1 C=0", display_on, cursor_on); end
        checks++; if (line1_text[127:112] !== 16'h4849) begin failures++; $display("FAIL hi_text: got %h want 4849", line1_text[127:112]); end
        checks++; if (line1_text !== exp_line(0)) begin failures++; $display("FAIL hi_line1: got %h want %h", line1_text, exp_line(0)); end
        checks++; if (ddram_address !== 7'h02) begin failures++; $display("FAIL hi_ac: got %h want 02", ddram_address); end
        checks++; if (ws_count - ws0 !== 3) begin failures++; $display("FAIL hi_strobes: got %0d want 3", ws_count - ws0); end
    endtask

    task automatic test_back_to_back_line2();
        send(1'b0, 1'b0, 8'hC0, 1, 0, 1'b0);
        for (int i = 0; i < 17; i++) send(1'b1, 1'b0, 8'h41, 1, 0, 1'b0);
        settle();
        checks++; if (line2_text !== {16{8'h41}}) begin failures++; $display("FAIL l2_fill: got %h want all 41", line2_text); end
        checks++; if (ddram_address !== 7'h51) begin failures++; $display("FAIL l2_ac: got %h want 51", ddram_address); end
        checks++; if (line1_text !== exp_line(0)) begin failures++; $display("FAIL l2_line1_kept: got %h want %h", line1_text, exp_line(0)); end
    endtask

    task automatic test_wrap();
        send(1'b0, 1'b0, 8'hA7, 1, 2, 1'b0);
        send(1'b1, 1'b0, 8'h58, 1, 2, 1'b0);
        settle();
        checks++; if (ddram_address !== 7'h40) begin failures++; $display("FAIL wrap_inc_ac: got %h want 40", ddram_address); end
        checks++; if (line1_text !== exp_line(0) || line2_text !== exp_line(1)) begin failures++; $display("FAIL wrap_text: got %h %h want %h %h", line1_text, line2_text, exp_line(0), exp_line(1)); end
        send(1'b0, 1'b0, 8'h04, 1, 2, 1'b0);
        send(1'b0, 1'b0, 8'h10, 1, 2, 1'b0);
        settle();
        checks++; if (ddram_address !== 7'h27) begin failures++; $display("FAIL wrap_dec_ac: got %h want 27", ddram_address); end
    endtask

    task automatic test_clear_busy();
        int b0;
        int waited;
        b0 = busy_cycles;
        send(1'b0, 1'b0, 8'h01, 1, 2, 1'b0);
        send(1'b1, 1'b0, 8'h51, 1, 0, 1'b1);
        waited = 0;
        while (busy === 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_timeout: busy=%b after %0d cycles want 0", busy, waited); end
        settle();
        checks++; if (busy_cycles - b0 !== 16) begin failures++; $display("FAIL clear_busy_len: got %0d want 16", busy_cycles - b0); end
        checks++; if (line1_text !== ALL_SPACES || line2_text !== ALL_SPACES) begin failures++; $display("FAIL clear_text: got %h %h want spaces", line1_text, line2_text); end
        checks++; if (ddram_address !== 7'h00) begin failures++; $display("FAIL clear_ac: got %h want 00", ddram_address); end
        send(1'b1, 1'b0, 8'h4B, 1, 2, 1'b0);
        settle();
        checks++; if (line1_text[127:120] !== 8'h4B || ddram_address !== m_ac) begin failures++; $display("FAIL clear_id_reset: got %h ac=%h want 4B ac=%h", line1_text[127:120], ddram_address, m_ac); end
    endtask

    task automatic test_rw_and_misc();
        send(1'b0, 1'b1, 8'h80, 1, 2, 1'b1);
        settle();
        checks++; if (ddram_address !== m_ac) begin failures++; $display("FAIL rw_reject_ac: got %h want %h", ddram_address, m_ac); end
        send(1'b0, 1'b0, 8'h0B, 1, 2, 1'b0);
        send(1'b0, 1'b0, 8'h02, 1, 2, 1'b0);
        send(1'b0, 1'b0, 8'h00, 1, 2, 1'b0);
        settle();
        checks++; if ({display_on, cursor_on, cursor_blink} !== {m_disp, m_cur, m_blink}) begin failures++; $display("FAIL dispctl: got %b%b%b want %b%b%b", display_on, cursor_on, cursor_blink, m_disp, m_cur, m_blink); end
        checks++; if (ddram_address !== 7'h00) begin failures++; $display("FAIL home_ac: got %h want 00", ddram_address); end
    endtask

    task automatic test_min_high();
        int lens[3] = '{2, 3, 4};
        int want_err[3] = '{1, 2, 2};
        int want_ws[3] = '{0, 0, 1};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h5A; lcd_e4 = 1'b1;
            repeat (lens[k]) @(negedge clk);
            lcd_e4 = 1'b0;
            settle();
            checks++; if (err4_count !== want_err[k] || ws4_count !== want_ws[k]) begin failures++; $display("FAIL min_high_len%0d: got err=%0d ws=%0d want err=%0d ws=%0d", lens[k], err4_count, ws4_count, want_err[k], want_ws[k]); end
        end
        checks++; if (l1_4[127:120] !== 8'h5A || ac4 !== 7'h01 || l1_4[119:0] !== ALL_SPACES[119:0]) begin failures++; $display("FAIL min_high_write: got %h ac=%h want 5A.. ac=01", l1_4, ac4); end
    endtask

    task automatic test_reset_mid_clear();
        send(1'b1, 1'b0, 8'h4D, 1, 2, 1'b0);
        send(1'b0, 1'b0, 8'h0C, 1, 2, 1'b0);
        send(1'b0, 1'b0, 8'h01, 1, 0, 1'b0);
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midclr_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (busy !== 1'b0 || ddram_address !== 7'h00 || display_on !== 1'b0) begin failures++; $display("FAIL midclr_reset: got busy=%b ac=%h D=%b want 0 00 0", busy, ddram_address, display_on); end
        checks++; if (line1_text !== ALL_SPACES || l1_4 !== ALL_SPACES) begin failures++; $display("FAIL midclr_text: got %h %h want spaces", line1_text, l1_4); end
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        checks++; if (busy !== 1'b0 || line1_text !== ALL_SPACES) begin failures++; $display("FAIL midclr_after: got busy=%b l1=%h want 0 spaces", busy, line1_text); end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (busy === 1'b1) busy_cycles++;
                if (write_strobe === 1'b1) ws_count++;
                if (ws4 === 1'b1) ws4_count++;
                if (err4 === 1'b1) err4_count++;
                if (write_strobe === 1'b1 || proto_error === 1'b1) begin
                    int got, want;
                    got = (write_strobe === 1'b1 && proto_error === 1'b1) ? 2 : (proto_error === 1'b1 ? 1 : 0);
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL pulse_unexpected: got kind %0d want no pulse", got);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            failures++;
                            $display("FAIL pulse_kind: got %0d want %0d (0=strobe 1=error)", got, want);
                        end
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        test_reset();
        test_display_hi();
        test_back_to_back_line2();
        test_wrap();
        test_clear_busy();
        test_rw_and_misc();
        test_min_high();
        test_reset_mid_clear();
        settle();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL pulses_missing: got %0d unconsumed want 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
